// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: key-schedule state encoding, permutation tables and
// the bit-level helpers reused by every S-DES stage.
package sdes_pkg;

  // P10 is a reserved encoding; the P10 load happens on the IDLE handshake.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P10    = 3'd1,
    SHIFT1 = 3'd2,
    SHIFT2 = 3'd3,
    DONE   = 3'd4
  } state_t;

  // 1-based source positions; position 1 is bit 0 (the MSB) of a [0:N] vector.
  localparam int P10_TABLE [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_TABLE  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};

  function automatic logic [0:9] p10(input logic [0:9] k);
    logic [0:9] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[4'(i)] = k[4'(P10_TABLE[i] - 1)];
    return r;
  endfunction

  function automatic logic [0:7] p8(input logic [0:9] k);
    logic [0:7] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(i)] = k[4'(P8_TABLE[i] - 1)];
    return r;
  endfunction

  // Rotate one 5-bit half left by n; halves never exchange bits.
  function automatic logic [0:4] ls(input logic [0:4] half, input int n);
    logic [0:4] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[3'(i)] = half[3'((i + n) % 5)];
    return r;
  endfunction

endpackage

// File: rtl/sdes_p8.sv
// Combinational P8 compression: selects 8 of the 10 shift-register bits.
module sdes_p8
  import sdes_pkg::*;
(
  input  logic [0:9] din,
  output logic [0:7] dout
);

  assign dout = p8(din);

endmodule

// File: rtl/sdes_keygen.sv
// S-DES key schedule: takes a 10-bit master key on a handshake and presents
// subkeys k1/k2 three cycles later, in swapped order when decrypting.
module sdes_keygen
  import sdes_pkg::*;
#(
  parameter bit HOLD_KEYS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:9] key,
  input  logic       dec,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [0:7] k1,
  output logic [0:7] k2,
  output logic       keys_valid,
  input  logic       keys_ready,
  output logic       busy
);

  state_t     state, state_nxt;
  logic [0:9] sr;
  logic [0:9] sr_ls1, sr_ls2, sr_shift;
  logic [0:7] ka;
  logic [0:7] p8_out;
  logic       dec_r;
  logic       keys_taken;

  assign key_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign keys_taken = keys_valid && keys_ready;

  // LS-2 in SHIFT2 applies on top of the LS-1 already stored in sr.
  assign sr_ls1   = {ls(sr[0:4], 1), ls(sr[5:9], 1)};
  assign sr_ls2   = {ls(sr[0:4], 2), ls(sr[5:9], 2)};
  assign sr_shift = (state == SHIFT2) ? sr_ls2 : sr_ls1;

  sdes_p8 u_p8 (
    .din  (sr_shift),
    .dout (p8_out)
  );

  always_comb begin
    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (key_valid) state_nxt = SHIFT1;
      SHIFT1:  state_nxt = SHIFT2;
      SHIFT2:  state_nxt = DONE;
      DONE:    if (keys_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: working registers are not reset; they are always reloaded before anything reads them.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (key_valid) begin
          sr    <= p10(key);
          dec_r <= dec;
        end
      end
      SHIFT1: begin
        sr <= sr_shift;
        ka <= p8_out;
      end
      SHIFT2:  sr <= sr_shift;
      default: ;
    endcase
  end

  // keys_valid rises one cycle into DONE, giving the 3-edge latency after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      k1         <= '0;
      k2         <= '0;
      keys_valid <= 1'b0;
    end else begin
      case (state)
        SHIFT2: begin
          k1 <= dec_r ? p8_out : ka;
          k2 <= dec_r ? ka : p8_out;
        end
        DONE: begin
          if (keys_taken) begin
            keys_valid <= 1'b0;
            if (!HOLD_KEYS) begin
              k1 <= '0;
              k2 <= '0;
            end
          end else begin
            keys_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdes_keygen.sv
// Self-checking bench for sdes_keygen: directed and random keys compared against
// an integer-arithmetic S-DES model, plus an fk/SW/fk round-trip check.
module tb_sdes_keygen;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:9] key;
  logic       dec;
  logic       key_valid;
  logic       key_ready;
  logic [0:7] k1, k2;
  logic       keys_valid;
  logic       keys_ready;
  logic       busy;
  logic       nh_key_ready, nh_keys_valid, nh_busy;
  logic [0:7] nh_k1, nh_k2;

  int total = 0;
  int bad   = 0;

  // Permutation tables as nibble lists, read left to right (1-based positions).
  localparam longint TAB_P10 = 64'h0000_0035_274A_1986;
  localparam longint TAB_P8  = 64'h0000_0000_6374_85A9;
  localparam longint TAB_IP  = 64'h0000_0000_2631_4857;
  localparam longint TAB_IPI = 64'h0000_0000_4135_7286;
  localparam longint TAB_EP  = 64'h0000_0000_4123_2341;
  localparam longint TAB_P4  = 64'h0000_0000_0000_2431;
  localparam int S0 [16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
  localparam int S1 [16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

  sdes_keygen #(.HOLD_KEYS(1'b1)) dut (
    .clk(clk), .rst(rst), .key(key), .dec(dec), .key_valid(key_valid),
    .key_ready(key_ready), .k1(k1), .k2(k2), .keys_valid(keys_valid),
    .keys_ready(keys_ready), .busy(busy)
  );

  sdes_keygen #(.HOLD_KEYS(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .key(key), .dec(dec), .key_valid(key_valid),
    .key_ready(nh_key_ready), .k1(nh_k1), .k2(nh_k2), .keys_valid(nh_keys_valid),
    .keys_ready(keys_ready), .busy(nh_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int permute(input int v, input int in_w, input longint tab, input int n);
    int r = 0;
    for (int i = 0; i < n; i++) begin
      int p;
      p = int'((tab >> (4 * (n - 1 - i))) & 64'hF);
      r = (r << 1) | ((v >> (in_w - p)) & 1);
    end
    return r;
  endfunction

  function automatic int rot5(input int h, input int n);
    return ((h << n) | (h >> (5 - n))) & 31;
  endfunction

  task automatic model_keys(input logic [9:0] k, input logic d,
                            output logic [7:0] e1, output logic [7:0] e2);
    int pk, l, r, ka, kb;
    pk = permute(int'(k), 10, TAB_P10, 10);
    l  = (pk >> 5) & 31;
    r  = pk & 31;
    l  = rot5(l, 1);
    r  = rot5(r, 1);
    ka = permute((l << 5) | r, 10, TAB_P8, 8);
    l  = rot5(l, 2);
    r  = rot5(r, 2);
    kb = permute((l << 5) | r, 10, TAB_P8, 8);
    e1 = d ? kb[7:0] : ka[7:0];
    e2 = d ? ka[7:0] : kb[7:0];
  endtask

  function automatic int fk(input int v, input int sk);
    int l, r, x, a, b, s0v, s1v, p;
    l   = (v >> 4) & 15;
    r   = v & 15;
    x   = permute(r, 4, TAB_EP, 8) ^ sk;
    a   = (x >> 4) & 15;
    b   = x & 15;
    s0v = S0[((((a >> 3) & 1) << 1) | (a & 1)) * 4 + ((a >> 1) & 3)];
    s1v = S1[((((b >> 3) & 1) << 1) | (b & 1)) * 4 + ((b >> 1) & 3)];
    p   = permute((s0v << 2) | s1v, 4, TAB_P4, 4);
    return ((l ^ p) << 4) | r;
  endfunction

  function automatic int sdes_model(input int blk, input int sk1, input int sk2);
    int x;
    x = permute(blk, 8, TAB_IP, 8);
    x = fk(x, sk1);
    x = ((x & 15) << 4) | ((x >> 4) & 15);
    x = fk(x, sk2);
    return permute(x, 8, TAB_IPI, 8);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a key, waits for acceptance, then counts edges until keys_valid (99 = never accepted).
  task automatic send_key(input logic [9:0] k, input logic d, output int lat);
    int w = 0;
    key = k;
    dec = d;
    key_valid = 1'b1;
    while (key_ready !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    tick();
    key_valid = 1'b0;
    lat = 0;
    while (keys_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    if (w >= 10) lat = 99;
  endtask

  task automatic release_keys();
    keys_ready = 1'b1;
    tick();
    keys_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; keys_ready = 1'b0; key = '0; dec = 1'b0;
    tick();
    tick();
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_key_ready got=%b exp=1", key_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (keys_valid !== 1'b0) begin bad++; $display("FAIL reset_keys_valid got=%b exp=0", keys_valid); end
    total++; if ({k1, k2} !== 16'h0000) begin bad++; $display("FAIL reset_keys got=%h exp=0000", {k1, k2}); end
    rst = 1'b0;
  endtask

  task automatic test_encrypt();
    int lat;
    send_key(10'b1010000010, 1'b0, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL enc_latency got=%0d exp=3", lat); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL enc_busy_done got=%b exp=1", busy); end
    total++; if (k1 !== 8'b10100100) begin bad++; $display("FAIL enc_k1 got=%b exp=10100100", k1); end
    total++; if (k2 !== 8'b01000011) begin bad++; $display("FAIL enc_k2 got=%b exp=01000011", k2); end
    release_keys();
    total++; if (keys_valid !== 1'b0 || key_ready !== 1'b1) begin bad++; $display("FAIL enc_release got=%b%b exp=01", keys_valid, key_ready); end
    total++; if (k1 !== 8'b10100100) begin bad++; $display("FAIL enc_hold_k1 got=%b exp=10100100", k1); end
    total++; if ({nh_k1, nh_k2} !== 16'h0000) begin bad++; $display("FAIL enc_clear_nohold got=%h exp=0000", {nh_k1, nh_k2}); end
  endtask

  task automatic test_decrypt();
    int lat, ct, pt;
    send_key(10'b1010000010, 1'b1, lat);
    total++; if (k1 !== 8'b01000011) begin bad++; $display("FAIL dec_k1 got=%b exp=01000011", k1); end
    total++; if (k2 !== 8'b10100100) begin bad++; $display("FAIL dec_k2 got=%b exp=10100100", k2); end
    // Encrypt with the encrypt-order keys (decrypt order swapped back), then decrypt with the DUT's decrypt-order keys.
    ct = sdes_model(32'h97, int'(k2), int'(k1));
    pt = sdes_model(ct, int'(k1), int'(k2));
    total++; if (pt !== 32'h97) begin bad++; $display("FAIL dec_round_trip got=%h exp=97", pt); end
    release_keys();
  endtask

  task automatic test_stall();
    int lat, n;
    logic [9:0] ka, kb;
    logic da, db;
    logic [7:0] e1, e2;
    ka = 10'($urandom_range(0, 1023)); da = 1'($urandom_range(0, 1));
    kb = 10'($urandom_range(0, 1023)); db = 1'($urandom_range(0, 1));
    model_keys(ka, da, e1, e2);
    send_key(ka, da, lat);
    key = kb; dec = db; key_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (keys_valid !== 1'b1 || key_ready !== 1'b0 || k1 !== e1 || k2 !== e2) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got=%b%b %h%h exp=10 %h%h", i, keys_valid, key_ready, k1, k2, e1, e2);
      end
      tick();
    end
    release_keys();
    total++; if (key_ready !== 1'b1 || keys_valid !== 1'b0) begin bad++; $display("FAIL stall_to_idle got=%b%b exp=10", key_ready, keys_valid); end
    tick();
    key_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_pending_accept got=%b exp=1", busy); end
    model_keys(kb, db, e1, e2);
    n = 0;
    while (keys_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++; if (n !== 3 || k1 !== e1 || k2 !== e2) begin bad++; $display("FAIL stall_pending_keys got=%0d %h%h exp=3 %h%h", n, k1, k2, e1, e2); end
    release_keys();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    key = 10'h3FF; dec = 1'b0; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_in_shift1 got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (key_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b%b exp=10", key_ready, busy); end
    total++; if (keys_valid !== 1'b0 || {k1, k2} !== 16'h0000) begin bad++; $display("FAIL rstmid_outputs got=%b %h exp=0 0000", keys_valid, {k1, k2}); end
    for (int i = 0; i < 6; i++) begin
      if (keys_valid !== 1'b0) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_output got=%0d exp=0", seen); end
    send_key(10'h000, 1'b0, lat);
    total++; if (lat !== 3 || {k1, k2} !== 16'h0000) begin bad++; $display("FAIL rstmid_zero_key got=%0d %h exp=3 0000", lat, {k1, k2}); end
    release_keys();
  endtask

  task automatic test_busy_toggle();
    int n = 0;
    key = 10'h3FF; dec = 1'b0; key_valid = 1'b1;
    tick();
    while (keys_valid !== 1'b1 && n < 10) begin
      key = 10'($urandom_range(0, 1023));
      dec = 1'($urandom_range(0, 1));
      key_valid = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    key_valid = 1'b0;
    total++; if (n !== 3) begin bad++; $display("FAIL toggle_latency got=%0d exp=3", n); end
    total++; if ({k1, k2} !== 16'hFFFF) begin bad++; $display("FAIL toggle_keys got=%h exp=ffff", {k1, k2}); end
    release_keys();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL toggle_no_spurious got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    int lat, st;
    logic [9:0] k;
    logic d;
    logic [7:0] e1, e2;
    for (int it = 0; it < 16; it++) begin
      k = 10'($urandom_range(0, 1023));
      d = 1'($urandom_range(0, 1));
      model_keys(k, d, e1, e2);
      send_key(k, d, lat);
      total++;
      if (lat !== 3 || k1 !== e1 || k2 !== e2) begin
        bad++;
        $display("FAIL random key=%h dec=%b got=%0d %h%h exp=3 %h%h", k, d, lat, k1, k2, e1, e2);
      end
      st = $urandom_range(0, 3);
      for (int i = 0; i < st; i++) tick();
      total++; if (keys_valid !== 1'b1) begin bad++; $display("FAIL random_stall got=%b exp=1", keys_valid); end
      release_keys();
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic [7:0] q1[$], q2[$];
    logic [7:0] e1, e2, last1, last2;
    logic [9:0] cur_k;
    logic cur_d, pre_ready, pre_valid;
    bit released = 1'b0;
    last1 = '0; last2 = '0;
    keys_ready = 1'b1;
    cur_k = 10'($urandom_range(0, 1023)); cur_d = 1'($urandom_range(0, 1));
    key = cur_k; dec = cur_d;
    for (int cyc = 0; cyc < 40; cyc++) begin
      key_valid = (cyc < 26);
      pre_ready = key_ready;
      pre_valid = key_valid;
      tick();
      if (pre_ready === 1'b1 && pre_valid) begin
        model_keys(cur_k, cur_d, e1, e2);
        q1.push_back(e1); q2.push_back(e2); acc.push_back(cyc);
        cur_k = 10'($urandom_range(0, 1023)); cur_d = 1'($urandom_range(0, 1));
        key = cur_k; dec = cur_d;
      end
      if (keys_valid === 1'b1) begin
        total++;
        if (q1.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_valid cyc=%0d", cyc);
        end else begin
          e1 = q1.pop_front(); e2 = q2.pop_front();
          if (k1 !== e1 || k2 !== e2) begin bad++; $display("FAIL b2b_keys cyc=%0d got=%h%h exp=%h%h", cyc, k1, k2, e1, e2); end
          last1 = e1; last2 = e2; released = 1'b1;
        end
      end else if (key_ready === 1'b1 && released) begin
        total++;
        if ({nh_k1, nh_k2} !== 16'h0000 || k1 !== last1 || k2 !== last2) begin
          bad++;
          $display("FAIL b2b_idle_keys cyc=%0d got=%h %h exp=0000 %h%h", cyc, {nh_k1, nh_k2}, {k1, k2}, last1, last2);
        end
      end
    end
    key_valid = 1'b0;
    keys_ready = 1'b0;
    total++; if (acc.size() < 5) begin bad++; $display("FAIL b2b_accept_count got=%0d exp>=5", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      total++;
      if (acc[i] - acc[i-1] !== 5) begin bad++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=5", i, acc[i] - acc[i-1]); end
    end
    total++; if (q1.size() !== 0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", q1.size()); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_stall();
    test_reset_mid();
    test_busy_toggle();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
